// File: rtl/add_operand_loader.sv
// add_operand_loader: collects up to 32 six-bit operands from a stream
// and presents them as one frame to the pairwise adder stage.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  operand stream handshake
//   in_data [0:5]      operand, bit 0 is the MSB
//   in_last            closes a short frame on the accepting cycle
//   frame_valid/ready  frame handshake toward the adder tree
//   op_frame [0:191]   operand k (1-based) at bits [6(k-1) +: 6]
//   op_count [0:5]     number of real operands in the frame, 1..32
module add_operand_loader #(
  parameter int N_OPS = 32,
  parameter int W     = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:W-1]       in_data,
  input  logic               in_last,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [0:N_OPS*W-1] op_frame,
  output logic [0:5]         op_count
);

  typedef enum logic {
    LOAD    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [4:0]   idx_q, idx_d;
  logic [0:5]   cnt_q, cnt_d;
  logic [0:W-1] slot_q [N_OPS];
  logic [0:W-1] slot_d [N_OPS];
  logic         accept;
  logic         close;

  assign in_ready    = (state_q == LOAD) & ~rst;
  assign frame_valid = (state_q == PRESENT);
  assign op_count    = cnt_q;

  always_comb begin
    for (int k = 0; k < N_OPS; k++) begin
      op_frame[k*W +: W] = slot_q[k];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    accept  = in_valid & in_ready;
    close   = accept & ((idx_q == 5'd31) | in_last);
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          slot_d[idx_q] = in_data;
          idx_d         = idx_q + 5'd1;
        end
        if (close) begin
          state_d = PRESENT;
          cnt_d   = {1'b0, idx_q} + 6'd1;
        end
      end
      PRESENT: begin
        // Clearing the bank on release is what makes the
        // unused slots of the next short frame read as zero.
        if (frame_ready) begin
          for (int k = 0; k < N_OPS; k++) begin
            slot_d[k] = '0;
          end
          idx_d   = '0;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      idx_q   <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < N_OPS; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
    end
  end

endmodule

// File: tb/tb_add_operand_loader.sv
// Scoreboard bench for add_operand_loader: a frame-level model turns the
// accepted operand stream into expected frames checked by a monitor.
module tb_add_operand_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [0:5]   in_data = '0;
  logic         in_last = 1'b0;
  logic         frame_valid;
  logic         frame_ready = 1'b1;
  logic [0:191] op_frame;
  logic [0:5]   op_count;

  always #5 clk = ~clk;

  add_operand_loader dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .op_frame    (op_frame),
    .op_count    (op_count)
  );

  typedef struct {
    logic [191:0] f;
    int           c;
  } exp_t;

  exp_t       sb[$];
  logic [5:0] cur[$];
  exp_t       held;
  int         checks = 0;
  int         passes = 0;
  int         frames_exp = 0;
  int         frames_seen = 0;
  bit         prev_fv = 1'b0;
  bit         prev_fr = 1'b0;

  task automatic chk(string nm, logic [191:0] act, logic [191:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chki(string nm, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Frame model: operands in arrival order, operand 1 in the top
  // six bits, zero padding, closed at 32 operands or on last.
  function automatic void model_accept(logic [5:0] d, bit last);
    exp_t e;
    cur.push_back(d);
    if (cur.size() == 32 || last) begin
      e.f = '0;
      foreach (cur[k]) e.f[191-6*k -: 6] = cur[k];
      e.c = cur.size();
      sb.push_back(e);
      frames_exp++;
      cur.delete();
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_fv = 1'b0;
      prev_fr = 1'b0;
    end else begin
      chki("in_ready", int'(in_ready), int'(!frame_valid));
      if (prev_fv && prev_fr)
        chki("release", int'(frame_valid), 0);
      if (prev_fv && !prev_fr) begin
        chki("hold_valid", int'(frame_valid), 1);
        chk("hold_frame", 192'(op_frame), held.f);
        chki("hold_count", int'(op_count), held.c);
      end
      if (frame_valid && !prev_fv) begin
        if (sb.size() == 0) begin
          chki("spurious_frame", int'(frame_valid), 0);
        end else begin
          held = sb.pop_front();
          frames_seen++;
          chk("frame", 192'(op_frame), held.f);
          chki("count", int'(op_count), held.c);
        end
      end else if (sb.size() != 0) begin
        chki("latency", int'(frame_valid), 1);
      end
      prev_fv = frame_valid;
      prev_fr = frame_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) begin
      in_data = 6'($urandom);
      in_last = 1'($urandom);
      tick();
    end
    in_last = 1'b0;
  endtask

  task automatic send(logic [5:0] d, bit last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready) begin
      frame_ready = 1'b1;
      n++;
      if (n > 100) begin
        chki("send_timeout", int'(in_ready), 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      tick();
    end
    @(posedge clk);
    model_accept(d, last);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_reset_vals(string nm);
    chki({nm, "_in_ready"}, int'(in_ready), 0);
    chki({nm, "_valid"}, int'(frame_valid), 0);
    chki({nm, "_count"}, int'(op_count), 0);
    chk({nm, "_frame"}, 192'(op_frame), '0);
  endtask

  initial begin
    int len;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 6'($urandom);
    repeat (3) tick();
    check_reset_vals("reset");
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    chki("ready_after_reset", int'(in_ready), 1);

    frame_ready = 1'b1;
    for (int i = 1; i <= 32; i++) send(6'(i), 1'b0);
    idle(3);

    send(6'd63, 1'b0);
    send(6'd5, 1'b0);
    send(6'd17, 1'b1);
    idle(3);

    frame_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(6'($urandom), i == 6);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom);
      in_data  = 6'($urandom);
      in_last  = 1'($urandom);
      tick();
    end
    in_valid    = 1'b0;
    in_last     = 1'b0;
    frame_ready = 1'b1;
    idle(3);

    for (int i = 1; i <= 32; i++) begin
      idle($urandom_range(0, 2));
      send(6'(i), 1'b0);
    end
    idle(3);

    for (int i = 0; i < 32; i++) send(6'($urandom), i == 31);
    idle(2);

    repeat (32) send(6'd1, 1'b0);
    repeat (32) send(6'd42, 1'b0);
    send(6'($urandom), 1'b0);
    send(6'($urandom), 1'b1);
    idle(3);

    send(6'($urandom), 1'b1);
    idle(2);

    repeat (20) send(6'($urandom), 1'b0);
    rst = 1'b1;
    cur.delete();
    tick();
    tick();
    check_reset_vals("midload_reset");
    rst = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) send(6'($urandom), 1'b0);
    idle(3);

    repeat (8) begin
      len = $urandom_range(1, 32);
      frame_ready = 1'($urandom);
      for (int i = 0; i < len; i++) begin
        idle($urandom_range(0, 1));
        send(6'($urandom), i == len - 1);
      end
    end
    frame_ready = 1'b1;
    idle(5);

    chki("scoreboard_empty", sb.size(), 0);
    chki("frames_seen", frames_seen, frames_exp);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, %0d/%0d", passes, checks);
    $fatal(1);
  end

endmodule
